// File: rtl/control_unit.sv
// Moore sequencer for the bus datapath: shared three-step fetch, opcode decode, per-opcode
// execute micro-steps, conditional branch PC load, Stop/Run handshake and halt.
module control_unit (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        stop_i,
    input  logic [31:0] ir_i,
    input  logic        con_i,
    output logic        run_o,
    output logic [4:0]  alu_op_o,
    output logic        hi_in_o,
    output logic        lo_in_o,
    output logic        pc_in_o,
    output logic        mdr_in_o,
    output logic        z_in_o,
    output logic        y_in_o,
    output logic        mar_in_o,
    output logic        ir_in_o,
    output logic        con_in_o,
    output logic        outport_in_o,
    output logic        hi_out_o,
    output logic        lo_out_o,
    output logic        zhi_out_o,
    output logic        zlo_out_o,
    output logic        pc_out_o,
    output logic        mdr_out_o,
    output logic        inport_out_o,
    output logic        c_out_o,
    output logic        ba_out_o,
    output logic        gra_o,
    output logic        grb_o,
    output logic        grc_o,
    output logic        r_in_o,
    output logic        r_out_o,
    output logic        read_o,
    output logic        write_o,
    output logic        inc_pc_o
);

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_STOP, S_HALT
    } state_e;

    localparam logic [4:0] OP_HALT = 5'd27;

    state_e     state_q, state_d, bnd;
    logic       run_q;
    logic [4:0] op;
    logic [2:0] len;
    logic       unused_ir;

    assign op        = ir_i[31:27];
    assign unused_ir = ^ir_i[26:0];
    assign run_o     = run_q;

    // Number of execute steps (T3 onward) for each opcode.
    always_comb begin
        len = 3'd0;
        if (op inside {5'd0, 5'd2})                 len = 3'd5;
        else if (op inside {5'd15, 5'd16, 5'd19})   len = 3'd4;
        else if (op inside {[5'd1:5'd14]})          len = 3'd3;
        else if (op inside {5'd17, 5'd18, 5'd21})   len = 3'd2;
        else if (op inside {5'd20, [5'd22:5'd25]})  len = 3'd1;
    end

    always_comb begin
        bnd     = stop_i ? S_STOP : S_T0;
        state_d = state_q;
        case (state_q)
            S_RST:  state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   state_d = S_T2;
            S_T2:   state_d = (op == OP_HALT) ? S_HALT : ((len == 3'd0) ? bnd : S_T3);
            S_T3:   state_d = (len == 3'd1) ? bnd : S_T4;
            S_T4:   state_d = (len == 3'd2) ? bnd : S_T5;
            S_T5:   state_d = (len == 3'd3) ? bnd : S_T6;
            S_T6:   state_d = (len == 3'd4) ? bnd : S_T7;
            S_T7:   state_d = bnd;
            S_STOP: state_d = stop_i ? S_STOP : S_T0;
            S_HALT: state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_RST;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= state_d inside {S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7};
        end
    end

    // Control lines decode from state and IR (and CON for the branch PC load).
    always_comb begin
        alu_op_o = 5'd0;
        {hi_in_o, lo_in_o, pc_in_o, mdr_in_o, z_in_o, y_in_o, mar_in_o, ir_in_o,
         con_in_o, outport_in_o} = '0;
        {hi_out_o, lo_out_o, zhi_out_o, zlo_out_o, pc_out_o, mdr_out_o, inport_out_o,
         c_out_o, ba_out_o} = '0;
        {gra_o, grb_o, grc_o, r_in_o, r_out_o, read_o, write_o, inc_pc_o} = '0;
        case (state_q)
            S_T0: begin pc_out_o = 1'b1; mar_in_o = 1'b1; end
            S_T1: begin read_o = 1'b1; mdr_in_o = 1'b1; pc_in_o = 1'b1; inc_pc_o = 1'b1; end
            S_T2: begin mdr_out_o = 1'b1; ir_in_o = 1'b1; end
            S_T3: begin
                if (op inside {[5'd3:5'd14]}) begin grb_o = 1'b1; r_out_o = 1'b1; y_in_o = 1'b1; end
                else if (op inside {[5'd0:5'd2]}) begin grb_o = 1'b1; ba_out_o = 1'b1; y_in_o = 1'b1; end
                else if (op inside {5'd15, 5'd16}) begin gra_o = 1'b1; r_out_o = 1'b1; y_in_o = 1'b1; end
                else if (op inside {5'd17, 5'd18}) begin
                    grb_o = 1'b1; r_out_o = 1'b1; z_in_o = 1'b1; alu_op_o = op;
                end
                else if (op == 5'd19) begin gra_o = 1'b1; r_out_o = 1'b1; con_in_o = 1'b1; end
                else if (op == 5'd20) begin gra_o = 1'b1; r_out_o = 1'b1; pc_in_o = 1'b1; end
                else if (op == 5'd21) begin pc_out_o = 1'b1; grb_o = 1'b1; r_in_o = 1'b1; end
                else if (op == 5'd22) begin inport_out_o = 1'b1; gra_o = 1'b1; r_in_o = 1'b1; end
                else if (op == 5'd23) begin gra_o = 1'b1; r_out_o = 1'b1; outport_in_o = 1'b1; end
                else if (op == 5'd24) begin hi_out_o = 1'b1; gra_o = 1'b1; r_in_o = 1'b1; end
                else if (op == 5'd25) begin lo_out_o = 1'b1; gra_o = 1'b1; r_in_o = 1'b1; end
            end
            S_T4: begin
                if (op inside {[5'd3:5'd11]}) begin
                    grc_o = 1'b1; r_out_o = 1'b1; z_in_o = 1'b1; alu_op_o = op;
                end
                else if (op inside {[5'd12:5'd14]}) begin c_out_o = 1'b1; z_in_o = 1'b1; alu_op_o = op; end
                else if (op inside {[5'd0:5'd2]}) begin c_out_o = 1'b1; z_in_o = 1'b1; alu_op_o = 5'd3; end
                else if (op inside {5'd15, 5'd16}) begin
                    grb_o = 1'b1; r_out_o = 1'b1; z_in_o = 1'b1; alu_op_o = op;
                end
                else if (op inside {5'd17, 5'd18}) begin zlo_out_o = 1'b1; gra_o = 1'b1; r_in_o = 1'b1; end
                else if (op == 5'd19) begin pc_out_o = 1'b1; y_in_o = 1'b1; end
                else if (op == 5'd21) begin gra_o = 1'b1; r_out_o = 1'b1; pc_in_o = 1'b1; end
            end
            S_T5: begin
                if (op inside {[5'd1:5'd14]} && op != 5'd2) begin
                    zlo_out_o = 1'b1; gra_o = 1'b1; r_in_o = 1'b1;
                end
                else if (op inside {5'd0, 5'd2}) begin zlo_out_o = 1'b1; mar_in_o = 1'b1; end
                else if (op inside {5'd15, 5'd16}) begin zlo_out_o = 1'b1; lo_in_o = 1'b1; end
                else if (op == 5'd19) begin c_out_o = 1'b1; z_in_o = 1'b1; alu_op_o = 5'd3; end
            end
            S_T6: begin
                if (op == 5'd0) begin read_o = 1'b1; mdr_in_o = 1'b1; end
                else if (op == 5'd2) begin gra_o = 1'b1; r_out_o = 1'b1; mdr_in_o = 1'b1; end
                else if (op inside {5'd15, 5'd16}) begin zhi_out_o = 1'b1; hi_in_o = 1'b1; end
                else if (op == 5'd19) begin zlo_out_o = 1'b1; pc_in_o = con_i; end
            end
            S_T7: begin
                if (op == 5'd0) begin mdr_out_o = 1'b1; gra_o = 1'b1; r_in_o = 1'b1; end
                else if (op == 5'd2) write_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/control_unit.md
# control_unit

Moore-style sequencer that drives every control line of the bus-based datapath. It performs the shared three-step fetch (T0–T2), decodes IR[31:27], and steps through the execute micro-sequence for that opcode. It also handles the conditional PC load for branches, the Stop/Run handshake and halt. It replaces the hand-written per-instruction control tables currently used to exercise the datapath.

## Interface
Parameters:
- none (opcode map fixed below)

Ports:
- Clock  in  1  system clock; all state changes on rising edge
- Reset  in  1  asynchronous, active-low; forces state RST
- Stop  in  1  pause request, sampled at instruction boundary
- IR  in  32  instruction register contents; opcode = IR[31:27]
- CON  in  1  branch-condition flop output from datapath
- Run  out  1  1 while executing; 0 in RST, STOPPED, HALTED
- AluOp  out  5  ALU operation select; 0 when Zin=0
- HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin  out  1 each  register load enables
- HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout, BAout  out  1 each  bus drive selects
- Gra, Grb, Grc, Rin, Rout  out  1 each  register-file field select and enable
- Read, Write, IncPC  out  1 each  memory read, memory write, PC increment

## Operation
- States: RST, T0–T7, STOPPED, HALTED. Outputs are a pure decode of state plus IR and CON. Every output not listed for a step is 0.
- Fetch:
  - T0: PCout, MARin
  - T1: Read, MDRin, PCin, IncPC
  - T2: MDRout, IRin
- Opcodes 3–11 (add, sub, and, or, ror, rol, shr, shra, shl):
  - T3: Grb, Rout, Yin
  - T4: Grc, Rout, Zin, AluOp=opcode
  - T5: ZLOout, Gra, Rin
- Opcodes 12–14 (addi, andi, ori):
  - T3: Grb, Rout, Yin
  - T4: Cout, Zin, AluOp = opcode
  - T5: ZLOout, Gra, Rin
- ldi (1):
  - T3: Grb, BAout, Yin
  - T4: Cout, Zin, AluOp = 3
  - T5: ZLOout, Gra, Rin
- ld (0):
  - T3–T5 as ldi, except T5 = ZLOout, MARin
  - T6: Read, MDRin
  - T7: MDRout, Gra, Rin
- st (2):
  - T3–T5 as ld
  - T6: Gra, Rout, MDRin (Read=0)
  - T7: Write
- mul/div (15, 16):
  - T3: Gra, Rout, Yin
  - T4: Grb, Rout, Zin, AluOp = opcode
  - T5: ZLOout, LOin
  - T6: ZHIout, HIin
- neg/not (17, 18):
  - T3: Grb, Rout, Zin, AluOp = opcode
  - T4: ZLOout, Gra, Rin
- br (19):
  - T3: Gra, Rout, CONin
  - T4: PCout, Yin
  - T5: Cout, Zin, AluOp = 3
  - T6: ZLOout, and PCin only if CON=1
- Single-step execute opcodes:
  - jr (20): T3 = Gra, Rout, PCin
  - jal (21): T3 = PCout, Grb, Rin; T4 = Gra, Rout, PCin
  - in (22): T3 = INPORTout, Gra, Rin
  - out (23): T3 = Gra, Rout, OUTPORTin
  - mfhi (24): T3 = HIout, Gra, Rin
  - mflo (25): T3 = LOout, Gra, Rin
- nop (26) and undefined opcodes (28–31): no T3 step.
- halt (27): after T2, next state HALTED. HALTED exits only via Reset.
- After the last step of any instruction, the next state is T0, or STOPPED if Stop=1 at that edge.
- STOPPED: all outputs 0 and Run=0. Returns to T0 on the first edge with Stop=0.

## Timing
- Reset asserted: state RST immediately (asynchronous). All outputs 0, Run=0.
- First rising edge after Reset deasserts: RST -> T0, Run=1.
- Cycles per instruction, including fetch:
  - nop/undefined: 3
  - jr, in, out, mfhi, mflo: 4
  - jal, neg, not: 5
  - ALU register, immediate and ldi: 6
  - br, mul, div: 7
  - ld, st: 8
- IR is loaded at the T2->T3 edge and is required stable from T3 to instruction end.
- CON is loaded by the T3 CONin edge. It is sampled combinationally during br T6.
- Stop is checked only at instruction boundaries. Asserting it mid-instruction never truncates the sequence.
- Stop=1 together with halt: HALTED takes priority.
- Reset during any state, including mid-store T7: Write drops immediately and the instruction is abandoned.

## Test plan
- Reset low 2 cycles, then high -> all outputs 0 during reset; T0 on the first edge with PCout=MARin=1; Run=1.
- IR=add (opcode 3) -> T3 Grb/Rout/Yin, T4 Grc/Rout/Zin with AluOp=3, T5 ZLOout/Gra/Rin, next cycle T0; 6 cycles total.
- IR=ld then IR=st -> ld T6 Read=MDRin=1, T7 MDRout/Gra/Rin; st T7 Write=1 with Read=0; 8 cycles each.
- IR=brmi with CON=1, then CON=0 -> T6 PCin=1 in the taken case; PCin=0 in the not-taken case, with ZLOout=1 in both; 7 cycles.
- Stop=1 raised during add T4 -> add completes T5; state STOPPED with Run=0 and all outputs 0; Stop=0 -> T0 next edge.
- IR=halt -> HALTED after T2 and stays there for 20 cycles; Reset pulse mid-st T7 -> Write falls without waiting for a clock edge.
